// File: rtl/sqrt_rebuild.sv
// Rebuilds a radicand from a square-root result: dout = root*root + rem, and flags
// whether the pair is a legal root/remainder result (rem <= 2*root).
module sqrt_rebuild #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_rdy,
    input  logic [W-1:0]     din_root,
    input  logic [W:0]       din_rem,
    output logic [2*W-1:0]   dout,
    output logic             dout_rdy,
    output logic             valid,
    output logic             busy
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    root_q, root_d;
    logic [W:0]      r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  dout_q, dout_d;
    logic            dout_rdy_q, dout_rdy_d;
    logic            valid_q, valid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            root_q     <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            dout_rdy_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            root_q     <= root_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dout_rdy_q <= dout_rdy_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        root_d     = root_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        dout_rdy_d = dout_rdy_q;
        valid_d    = valid_q;

        case (state_q)
            IDLE, DONE: begin
                if (din_rdy) begin
                    a_d        = {{W{1'b0}}, din_root};
                    b_d        = din_root;
                    root_d     = din_root;
                    r_d        = din_rem;
                    acc_d      = '0;
                    cnt_d      = '0;
                    dout_rdy_d = 1'b0;
                    state_d    = MUL;
                end
            end
            // Shift-add step; always exactly W steps regardless of operand value.
            MUL: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                dout_d     = acc_q + {{(W-1){1'b0}}, r_q};
                valid_d    = (r_q <= {root_q, 1'b0});
                dout_rdy_d = 1'b1;
                state_d    = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout     = dout_q;
    assign dout_rdy = dout_rdy_q;
    assign valid    = valid_q;
    assign busy     = (state_q == MUL) || (state_q == ADD);

endmodule

// File: tb/tb_sqrt_rebuild.sv
// Scoreboard bench for sqrt_rebuild: stimulus pushes hand-computed results, a
// monitor pops and compares on every rising dout_rdy, including latency.
module tb_sqrt_rebuild;

    localparam int W       = 16;
    localparam int LATENCY = W + 1;

    logic            clk;
    logic            rst;
    logic            din_rdy;
    logic [W-1:0]    din_root;
    logic [W:0]      din_rem;
    logic [2*W-1:0]  dout;
    logic            dout_rdy;
    logic            valid;
    logic            busy;

    typedef struct {
        logic [2*W-1:0] dout;
        logic           valid;
        int             sample;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prevRdy  = 1'b0;

    typedef struct {
        logic [W-1:0]   root;
        logic [W:0]     rem;
        logic [2*W-1:0] dout;
        logic           valid;
    } vec_t;

    vec_t vecs[$];

    sqrt_rebuild #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .din_rdy  (din_rdy),
        .din_root (din_root),
        .din_rem  (din_rem),
        .dout     (dout),
        .dout_rdy (dout_rdy),
        .valid    (valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every new result is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && dout_rdy && !prevRdy) begin
            checkOutput("rdyWhileBusy", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                checkOutput("unexpectedResult", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("dout", dout, e.dout);
                checkOutput("valid", {31'd0, valid}, {31'd0, e.valid});
                checkOutput("latency", cyc - e.sample, LATENCY);
            end
        end
        prevRdy = dout_rdy;
    end

    task automatic waitReady();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dout_rdy) return;
        end
        checkOutput("readyTimeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [W-1:0] root, input logic [W:0] rem,
                                 input logic [2*W-1:0] expD, input logic expV);
        int  busyCnt;
        bit  seen;
        exp_t e;
        busyCnt = 0;
        seen    = 1'b0;
        @(negedge clk);
        din_root = root;
        din_rem  = rem;
        din_rdy  = 1'b1;
        e.dout   = expD;
        e.valid  = expV;
        e.sample = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        din_rdy  = 1'b0;
        din_root = 16'hBEEF;
        din_rem  = 17'h1ABCD;
        for (int i = 0; i < 40; i++) begin
            if (dout_rdy) begin
                seen = 1'b1;
                break;
            end
            if (busy) busyCnt++;
            @(negedge clk);
        end
        if (!seen) checkOutput("readyTimeout", 32'd0, 32'd1);
        checkOutput("busyCycles", busyCnt, LATENCY);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst      = 1'b0;
        din_rdy  = 1'b0;
        din_root = '0;
        din_rem  = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetDout", dout, 32'd0);
        checkOutput("resetRdy", {31'd0, dout_rdy}, 32'd0);
        checkOutput("resetValid", {31'd0, valid}, 32'd0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        vecs.push_back('{16'd0,     17'd0,      32'd0,          1'b1});
        vecs.push_back('{16'd4,     17'd2,      32'd18,         1'b1});
        vecs.push_back('{16'd3,     17'd7,      32'd16,         1'b0});
        vecs.push_back('{16'd65535, 17'd131070, 32'hFFFFFFFF,   1'b1});
        vecs.push_back('{16'd65535, 17'd131071, 32'h00000000,   1'b0});
        vecs.push_back('{16'd1,     17'd3,      32'd4,          1'b0});
        vecs.push_back('{16'd255,   17'd510,    32'd65535,      1'b1});
        vecs.push_back('{16'd2,     17'd4,      32'd8,          1'b1});
        foreach (vecs[i]) applyStimulus(vecs[i].root, vecs[i].rem, vecs[i].dout, vecs[i].valid);

        // Back-to-back: din_rdy held, operands swapped at the first result.
        @(negedge clk);
        din_root = 16'd46340;
        din_rem  = 17'd0;
        din_rdy  = 1'b1;
        e = '{32'd2147395600, 1'b1, cyc + 1};
        sb.push_back(e);
        repeat (3) @(negedge clk);
        din_root = 16'h1234;
        din_rem  = 17'h1FFFF;
        din_rdy  = 1'b0;
        @(negedge clk);
        din_rdy  = 1'b1;
        waitReady();
        din_root = 16'd1;
        din_rem  = 17'd1;
        e = '{32'd2, 1'b1, cyc + 1};
        sb.push_back(e);
        @(negedge clk);
        checkOutput("rdyDropOnRestart", {31'd0, dout_rdy}, 32'd0);
        checkOutput("busyOnRestart", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        din_rdy  = 1'b0;
        din_root = 16'd777;
        @(negedge clk);
        din_rdy  = 1'b1;
        @(negedge clk);
        din_rdy  = 1'b0;
        waitReady();
        @(negedge clk);

        applyStimulus(16'd2, 17'd4, 32'd8, 1'b1);

        // Reset during MUL: the in-flight expectation is withdrawn.
        @(negedge clk);
        din_root = 16'd1000;
        din_rem  = 17'd5;
        din_rdy  = 1'b1;
        e = '{32'd1000005, 1'b1, cyc + 1};
        sb.push_back(e);
        @(negedge clk);
        din_rdy = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midResetDout", dout, 32'd0);
        checkOutput("midResetValid", {31'd0, valid}, 32'd0);
        checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("midResetRdy", {31'd0, dout_rdy}, 32'd0);
        sb.delete(sb.size() - 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idleAfterReset", {31'd0, busy}, 32'd0);

        applyStimulus(16'd1000, 17'd5, 32'd1000005, 1'b1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
